shift_light_engine: RTL

SHIFT_LIGHT_ENGINE -- requirements
Module: shift_light_engine

---
 rtl/shift_light_engine.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/shift_light_engine.sv
// Light-pattern sequencer: a free-running prescaler paces shift-in, rotate, bounce and hold modes.
// Define SHIFT_LIGHT_BOUNCE_EN to build bounce mode. Without it, mode 10 holds the pattern.
module shift_light_engine #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 23
) (
    input  logic             clk_50,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic [1:0]       speed,
    input  logic             inject,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] pattern,
    output logic             step,
    output logic             wrap
);

    typedef enum logic [1:0] {
        MODE_SHIFT  = 2'b00,
        MODE_ROTATE = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] step_mask;
    logic [WIDTH-1:0] pattern_q, pattern_d;
    logic             wrap_q, wrap_d;

    function automatic logic [WIDTH-1:0] shl(input logic [WIDTH-1:0] p, input logic fill);
        return {p[WIDTH-2:0], fill};
    endfunction

    function automatic logic [WIDTH-1:0] shr(input logic [WIDTH-1:0] p, input logic fill);
        return {fill, p[WIDTH-1:1]};
    endfunction

    // The step decode looks at only the low DIV_W-speed bits, so a speed change
    // takes effect on the very next matching count without disturbing the counter.
    assign cnt_d     = cnt_q + DIV_W'(1);
    assign step_mask = {DIV_W{1'b1}} >> speed;
    assign step      = &(cnt_q | ~step_mask);

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef SHIFT_LIGHT_BOUNCE_EN
    logic             bounce_right_q, bounce_right_d;
    logic [WIDTH-1:0] bounce_pat;
    logic             bounce_turn;

    always_comb begin
        bounce_pat     = pattern_q;
        bounce_turn    = 1'b0;
        bounce_right_d = bounce_right_q;
        if (pattern_q == '0) begin
            bounce_pat     = WIDTH'(1);
            bounce_right_d = 1'b0;
        end else if (!bounce_right_q) begin
            if (pattern_q[WIDTH-1]) begin
                bounce_turn    = 1'b1;
                bounce_right_d = 1'b1;
                bounce_pat     = shr(pattern_q, 1'b0);
            end else begin
                bounce_pat = shl(pattern_q, 1'b0);
            end
        end else begin
            if (pattern_q[0]) begin
                bounce_turn    = 1'b1;
                bounce_right_d = 1'b0;
                bounce_pat     = shl(pattern_q, 1'b0);
            end else begin
                bounce_pat = shr(pattern_q, 1'b0);
            end
        end
        // Direction only moves on an applied bounce step; clear re-homes it.
        if (clear) begin
            bounce_right_d = 1'b0;
        end else if (load || !step || (mode != MODE_BOUNCE)) begin
            bounce_right_d = bounce_right_q;
        end
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            bounce_right_q <= 1'b0;
        end else begin
            bounce_right_q <= bounce_right_d;
        end
    end
`endif

    always_comb begin
        pattern_d = pattern_q;
        wrap_d    = 1'b0;
        if (clear) begin
            pattern_d = '0;
        end else if (load) begin
            pattern_d = load_data;
        end else if (step) begin
            case (mode)
                MODE_SHIFT: begin
                    pattern_d = dir ? shr(pattern_q, inject) : shl(pattern_q, inject);
                end
                MODE_ROTATE: begin
                    pattern_d = dir ? shr(pattern_q, pattern_q[0]) : shl(pattern_q, pattern_q[WIDTH-1]);
                    wrap_d    = dir ? pattern_q[0] : pattern_q[WIDTH-1];
                end
                MODE_BOUNCE: begin
`ifdef SHIFT_LIGHT_BOUNCE_EN
                    pattern_d = bounce_pat;
                    wrap_d    = bounce_turn;
`else
                    pattern_d = pattern_q;
`endif
                end
                default: begin
                    pattern_d = pattern_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            pattern_q <= '0;
            wrap_q    <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            wrap_q    <= wrap_d;
        end
    end

    assign pattern = pattern_q;
    assign wrap    = wrap_q;

endmodule
